mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port of the tinker core between the instruction-fetch requester and the data (load/store) requester. Handshakes are req/gnt/rvalid, with one transaction outstanding at a time. Data has priority, bounded by an anti-starvation counter that forces a fetch grant after a run of data grants. Out-of-range accesses are rejected with an error response and never reach the memory.

## Interface
- ADDR_W, 32, address width for all ports
- MEM_BYTES, 524288, memory size in bytes; legal range is 0..MEM_BYTES-1
- MAX_DATA_RUN, 4, consecutive data grants allowed while fetch waits (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- f_req  in  1  fetch request; held with f_addr until f_gnt
- f_addr  in  ADDR_W  fetch byte address; access is 4 bytes
- f_gnt  out  1  one-cycle grant pulse to fetch
- f_rvalid  out  1  one-cycle fetch response pulse
- f_rdata  out  32  fetch data, equal to m_rdata[31:0]
- f_err  out  1  qualifies f_rvalid; fetch was out of range
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address; access is 8 bytes
- d_wdata  in  64  store data
- d_gnt  out  1  one-cycle grant pulse to data
- d_rvalid  out  1  one-cycle data response pulse; issued for loads and stores
- d_rdata  out  64  load data; 0 for stores and errors
- d_err  out  1  qualifies d_rvalid; data access was out of range
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory byte address
- m_wdata  out  64  memory write data
- m_ready  in  1  memory accepts m_req in this cycle
- m_rdata  in  64  read data, valid in the cycle after a read is accepted

## Operation
- FSM states: IDLE, ISSUE, RESP, ERR.
- **IDLE:** when any request is present at the clock edge, arbitrate as follows.
  - The winner's address, we and wdata are latched into m_addr, m_we and m_wdata.
  - The winner's gnt is asserted for the next cycle only.
  - The next state is ISSUE, or ERR if the address is out of range.
  - The fetch access is out of range when f_addr+3 ≥ MEM_BYTES; the data access when d_addr+7 ≥ MEM_BYTES. Compute both in ADDR_W+1 bits so the sum cannot wrap.
- **Arbitration:**
  - Data wins, unless f_req=1 and run_cnt==MAX_DATA_RUN, in which case fetch wins.
  - A data grant with f_req=1 sets run_cnt to run_cnt+1, saturating at MAX_DATA_RUN.
  - A fetch grant, or any arbitration with f_req=0, clears run_cnt.
- **ISSUE:** m_req=1 with m_addr, m_we and m_wdata held stable until m_ready=1.
  - On acceptance of a write: go to IDLE, and the owner's rvalid pulses in the next cycle.
  - On acceptance of a read: go to RESP.
- **RESP:** m_rdata is registered to the owner's rdata, with rvalid pulsed in the next cycle. The next state is IDLE.
- **ERR:** m_req=0; go to IDLE. The owner's rvalid and err pulse in the next cycle, with rdata=0.
- Requesters drop req in the cycle after gnt unless a new request is pending. A req sampled in IDLE always counts as a new request.
- rdata holds its last value between rvalid pulses. err is 0 whenever rvalid is 0.
- Addresses are passed through unmodified; there is no alignment check.

## Timing
- All outputs are registered.
- Async reset clears all outputs, the state (to IDLE) and run_cnt (to 0) immediately. It does not wait for clk.
- Read, with the request sampled at edge 0 and m_ready=1 in cycle 1:
  - gnt and m_req in cycle 1
  - RESP in cycle 2
  - rvalid in cycle 3
- Write: gnt and m_req in cycle 1, rvalid in cycle 2.
- Error: gnt in cycle 1, rvalid and err in cycle 2; m_req stays 0.
- m_ready low stalls ISSUE one cycle per low cycle. Each stall cycle adds one cycle to the response.
- The rvalid cycle coincides with IDLE, so a new request can be granted in the cycle after rvalid.
- Throughput: reads one per 3 cycles, writes and errors one per 2 cycles.
- A reset asserted in ISSUE or RESP abandons the transaction: m_req drops in the same cycle and no rvalid is produced. The first request after reset deasserts is served normally.

## Test plan
- **Single fetch read:** f_req with f_addr=0x2000 at edge 0, m_ready=1, m_rdata=0x11223344_AABBCCDD in cycle 2. Required: f_gnt, m_req and m_addr=0x2000 in cycle 1; f_rvalid=1 with f_rdata=0xAABBCCDD in cycle 3.
- **Simultaneous requests:** f_req and d_req (load at 0x100) together. Required: d_gnt first; f_gnt at the next IDLE (cycle 4); f_err=d_err=0.
- **Starvation bound:** d_req held continuously as back-to-back loads, f_req held. Required: exactly 4 d_gnt pulses, then 1 f_gnt, then data again.
- **Backpressure store:** d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF_00000001, m_ready low for cycles 1-3. Required: m_req, m_we, m_addr and m_wdata stable in cycles 1-4; d_rvalid in cycle 5 with d_rdata=0.
- **Out of range:** d_addr=0x7FFF9 (0x7FFF9+7 = 0x80000 ≥ MEM_BYTES). Required: d_gnt in cycle 1, m_req never asserted, d_rvalid=d_err=1 in cycle 2 with d_rdata=0. Also f_addr=0x7FFFC: accepted; response with f_err=0.
- **Reset mid-operation:** assert reset in cycle 1 of a read (ISSUE). Required: m_req, f_gnt and all outputs 0 immediately; no f_rvalid; after release, a new f_req is served with standard 3-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store requesters. One transaction in flight at a time; data has
// priority, but a run of data grants while fetch waits is capped so fetch is
// never starved. Accesses that would run past the end of memory are answered
// with an error response and never reach the memory port.

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MEM_BYTES    = 524288,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_wdata,
  input  logic              m_ready,
  input  logic [63:0]       m_rdata
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_DATA_RUN);
  localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;

  state_t           state;
  state_t           state_next;
  logic [RUN_W-1:0] run_cnt;
  logic             owner_fetch;
  logic             any_req;
  logic             fetch_wins;
  logic             f_oor;
  logic             d_oor;
  logic             win_oor;
  logic [ADDR_W:0]  f_end;
  logic [ADDR_W:0]  d_end;

  // Arbitration decision, range checks (one extra bit so the end address cannot wrap) and next state
  always_comb begin
    state_next = state;
    f_end      = {1'b0, f_addr} + (ADDR_W+1)'(3);
    d_end      = {1'b0, d_addr} + (ADDR_W+1)'(7);
    f_oor      = (f_end >= MEM_LIMIT);
    d_oor      = (d_end >= MEM_LIMIT);
    any_req    = f_req | d_req;
    fetch_wins = f_req && (!d_req || (run_cnt == RUN_MAX));
    win_oor    = fetch_wins ? f_oor : d_oor;
    case (state)
      IDLE:    if (any_req) state_next = win_oor ? ERR : ISSUE;
      ISSUE:   if (m_ready) state_next = m_we ? IDLE : RESP;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Registered outputs: grant/response pulses, memory command, response data and the data-run counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_gnt       <= 1'b0;
      f_rvalid    <= 1'b0;
      f_rdata     <= '0;
      f_err       <= 1'b0;
      d_gnt       <= 1'b0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      owner_fetch <= 1'b0;
      run_cnt     <= '0;
    end else begin
      f_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      f_err    <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_fetch <= fetch_wins;
            f_gnt       <= fetch_wins;
            d_gnt       <= !fetch_wins;
            m_req       <= !win_oor;
            if (fetch_wins) begin
              m_addr  <= f_addr;
              m_we    <= 1'b0;
              m_wdata <= '0;
            end else begin
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
            end
            if (fetch_wins || !f_req) run_cnt <= '0;
            else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_W'(1);
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_req <= 1'b0;
            if (m_we) begin
              if (owner_fetch) begin
                f_rvalid <= 1'b1;
              end else begin
                d_rvalid <= 1'b1;
                d_rdata  <= '0;
              end
            end
          end
        end
        RESP: begin
          if (owner_fetch) begin
            f_rvalid <= 1'b1;
            f_rdata  <= m_rdata[31:0];
          end else begin
            d_rvalid <= 1'b1;
            d_rdata  <= m_rdata;
          end
        end
        ERR: begin
          if (owner_fetch) begin
            f_rvalid <= 1'b1;
            f_err    <= 1'b1;
            f_rdata  <= '0;
          end else begin
            d_rvalid <= 1'b1;
            d_err    <= 1'b1;
            d_rdata  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized single transactions
// and randomized fetch/data contention checked against a transaction-level model.

module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 524288;
  localparam int MAX_RUN   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              f_req, f_gnt, f_rvalid, f_err;
  logic [ADDR_W-1:0] f_addr;
  logic [31:0]       f_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata, d_rdata;
  logic              m_req, m_we, m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [63:0]       m_wdata, m_rdata;

  int checks = 0;
  int passes = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge (the start of the next cycle)
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    m_rdata = '0;
    tick(); tick();
    checks++; if ({f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, m_req, m_we} !== 8'h00)
      $display("[TB] FAIL reset_flags: got %b want 00000000", {f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, m_req, m_we}); else passes++;
    checks++; if ({f_rdata, d_rdata, m_addr, m_wdata} !== '0)
      $display("[TB] FAIL reset_data: got %h want 0", {f_rdata, d_rdata, m_addr, m_wdata}); else passes++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read;
    f_req = 1'b1; f_addr = 32'h2000; m_ready = 1'b1;
    tick();
    checks++; if ({f_gnt, d_gnt, m_req} !== 3'b101) $display("[TB] FAIL fr_gnt: got %b want 101", {f_gnt, d_gnt, m_req}); else passes++;
    checks++; if (m_addr !== 32'h2000) $display("[TB] FAIL fr_addr: got %h want 00002000", m_addr); else passes++;
    f_req = 1'b0;
    tick();
    checks++; if (f_rvalid !== 1'b0) $display("[TB] FAIL fr_early: got %b want 0", f_rvalid); else passes++;
    m_rdata = 64'h11223344_AABBCCDD;
    tick();
    checks++; if ({f_rvalid, f_err} !== 2'b10) $display("[TB] FAIL fr_rvalid: got %b want 10", {f_rvalid, f_err}); else passes++;
    checks++; if (f_rdata !== 32'hAABBCCDD) $display("[TB] FAIL fr_rdata: got %h want aabbccdd", f_rdata); else passes++;
    m_rdata = 64'h0;
    tick();
    checks++; if (f_rvalid !== 1'b0 || f_rdata !== 32'hAABBCCDD)
      $display("[TB] FAIL fr_hold: got %b/%h want 0/aabbccdd", f_rvalid, f_rdata); else passes++;
  endtask

  task automatic test_simultaneous;
    f_req = 1'b1; f_addr = 32'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    m_ready = 1'b1; m_rdata = 64'h01234567_89ABCDEF;
    tick();
    checks++; if ({d_gnt, f_gnt} !== 2'b10) $display("[TB] FAIL sim_first: got d/f %b want 10", {d_gnt, f_gnt}); else passes++;
    d_req = 1'b0;
    tick(); tick();
    checks++; if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 64'h01234567_89ABCDEF)
      $display("[TB] FAIL sim_dresp: got %b %h want 10 0123456789abcdef", {d_rvalid, d_err}, d_rdata); else passes++;
    tick();
    checks++; if ({f_gnt, d_gnt} !== 2'b10) $display("[TB] FAIL sim_second: got f/d %b want 10", {f_gnt, d_gnt}); else passes++;
    f_req = 1'b0;
    tick(); tick();
    checks++; if ({f_rvalid, f_err} !== 2'b10 || f_rdata !== 32'h89ABCDEF)
      $display("[TB] FAIL sim_fresp: got %b %h want 10 89abcdef", {f_rvalid, f_err}, f_rdata); else passes++;
    tick();
  endtask

  task automatic test_starvation;
    bit is_f[7];
    int n = 0;
    int cyc = 0;
    bit seen;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    f_req = 1'b1; f_addr = 32'h400;
    m_ready = 1'b1; m_rdata = 64'hCAFEF00D_12345678;
    while (n < 7 && cyc < 100) begin
      tick(); cyc++;
      if (f_gnt || d_gnt) begin
        is_f[n] = f_gnt;
        n++;
        if (f_gnt) f_req = 1'b0;
        if (n == 7) d_req = 1'b0;
      end
    end
    checks++; if (n != 7) $display("[TB] FAIL starve_budget: got %0d grants want 7", n); else passes++;
    for (int i = 0; i < 7; i++) begin
      checks++; if (is_f[i] !== (i == 4)) $display("[TB] FAIL starve_order[%0d]: got fetch=%b want %b", i, is_f[i], (i == 4)); else passes++;
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = d_rvalid;
    end
    checks++; if (!seen) $display("[TB] FAIL starve_drain: got no d_rvalid want d_rvalid"); else passes++;
    tick();
  endtask

  task automatic test_backpressure_store;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 64'hDEADBEEF_00000001;
    m_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (d_gnt !== 1'b1) $display("[TB] FAIL bp_gnt: got %b want 1", d_gnt); else passes++;
        d_req = 1'b0;
      end
      checks++; if ({m_req, m_we} !== 2'b11 || m_addr !== 32'h80 || m_wdata !== 64'hDEADBEEF_00000001)
        $display("[TB] FAIL bp_hold_c%0d: got %b %h %h want 11 00000080 deadbeef00000001", c, {m_req, m_we}, m_addr, m_wdata); else passes++;
      checks++; if (d_rvalid !== 1'b0) $display("[TB] FAIL bp_early_c%0d: got %b want 0", c, d_rvalid); else passes++;
      if (c == 4) m_ready = 1'b1;
    end
    tick();
    checks++; if ({d_rvalid, d_err, m_req} !== 3'b100 || d_rdata !== 64'h0)
      $display("[TB] FAIL bp_resp: got %b %h want 100 0", {d_rvalid, d_err, m_req}, d_rdata); else passes++;
    tick();
  endtask

  task automatic test_out_of_range;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7FFF9; m_ready = 1'b1;
    tick();
    checks++; if ({d_gnt, m_req} !== 2'b10) $display("[TB] FAIL oor_gnt: got %b want 10", {d_gnt, m_req}); else passes++;
    d_req = 1'b0;
    tick();
    checks++; if ({d_rvalid, d_err, m_req} !== 3'b110 || d_rdata !== 64'h0)
      $display("[TB] FAIL oor_resp: got %b %h want 110 0", {d_rvalid, d_err, m_req}, d_rdata); else passes++;
    tick();
    checks++; if ({d_rvalid, d_err} !== 2'b00) $display("[TB] FAIL oor_clear: got %b want 00", {d_rvalid, d_err}); else passes++;
    f_req = 1'b1; f_addr = 32'h7FFFC; m_rdata = 64'h55556666_77778888;
    tick();
    checks++; if ({f_gnt, m_req} !== 2'b11) $display("[TB] FAIL edge_gnt: got %b want 11", {f_gnt, m_req}); else passes++;
    f_req = 1'b0;
    tick(); tick();
    checks++; if ({f_rvalid, f_err} !== 2'b10 || f_rdata !== 32'h77778888)
      $display("[TB] FAIL edge_resp: got %b %h want 10 77778888", {f_rvalid, f_err}, f_rdata); else passes++;
    tick();
  endtask

  task automatic test_reset_mid;
    bit stray;
    f_req = 1'b1; f_addr = 32'h1000; m_ready = 1'b1;
    tick();
    checks++; if ({f_gnt, m_req} !== 2'b11) $display("[TB] FAIL rst_pre: got %b want 11", {f_gnt, m_req}); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if ({m_req, f_gnt, f_rvalid} !== 3'b000 || m_addr !== '0)
      $display("[TB] FAIL rst_async: got %b %h want 000 0", {m_req, f_gnt, f_rvalid}, m_addr); else passes++;
    f_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (f_rvalid || m_req) stray = 1'b1;
    end
    checks++; if (stray) $display("[TB] FAIL rst_stray: got activity after reset want none"); else passes++;
    f_req = 1'b1; f_addr = 32'h1004; m_rdata = 64'h0BAD0BAD_600DF00D;
    tick();
    checks++; if ({f_gnt, m_req} !== 2'b11 || m_addr !== 32'h1004)
      $display("[TB] FAIL rst_after_gnt: got %b %h want 11 00001004", {f_gnt, m_req}, m_addr); else passes++;
    f_req = 1'b0;
    tick(); tick();
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h600DF00D)
      $display("[TB] FAIL rst_after_resp: got %b %h want 1 600df00d", f_rvalid, f_rdata); else passes++;
    tick();
  endtask

  // One transaction at a time with random requester, address, stalls and data
  task automatic test_random_single;
    for (int t = 0; t < 40; t++) begin
      bit                is_f, we, err, got;
      int                stalls, size, exp_cyc, c;
      logic [ADDR_W-1:0] addr;
      logic [63:0]       wd, rd, exp_rd;
      longint unsigned   last;
      is_f   = 1'($urandom_range(0, 1));
      we     = is_f ? 1'b0 : 1'($urandom_range(0, 1));
      size   = is_f ? 4 : 8;
      case ($urandom_range(0, 3))
        0:       addr = 32'(MEM_BYTES - int'($urandom_range(1, 12)));
        1:       addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: addr = 32'($urandom_range(0, MEM_BYTES - 16));
      endcase
      stalls = $urandom_range(0, 3);
      wd     = {$urandom, $urandom};
      rd     = {$urandom, $urandom};
      last   = longint'(addr) + longint'(size - 1);
      err    = (last >= longint'(MEM_BYTES));
      exp_cyc = err ? 2 : (we ? 2 + stalls : 3 + stalls);
      exp_rd  = (err || we) ? 64'h0 : (is_f ? {32'h0, rd[31:0]} : rd);
      m_rdata = rd;
      m_ready = (stalls == 0);
      if (is_f) begin
        f_req = 1'b1; f_addr = addr;
      end else begin
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
      end
      tick();
      c = 1;
      checks++; if ({f_gnt, d_gnt} !== {is_f, !is_f} || m_req !== !err)
        $display("[TB] FAIL rnd%0d_gnt: got f/d/m %b want %b", t, {f_gnt, d_gnt, m_req}, {is_f, !is_f, !err}); else passes++;
      if (!err) begin
        checks++; if (m_addr !== addr || m_we !== we || (!is_f && m_wdata !== wd))
          $display("[TB] FAIL rnd%0d_cmd: got %h %b %h want %h %b %h", t, m_addr, m_we, m_wdata, addr, we, wd); else passes++;
      end
      f_req = 1'b0; d_req = 1'b0;
      m_ready = (c > stalls);
      got = 1'b0;
      while (!got && c < 12) begin
        tick(); c++;
        m_ready = (c > stalls);
        got = is_f ? f_rvalid : d_rvalid;
      end
      checks++; if (!got || c != exp_cyc)
        $display("[TB] FAIL rnd%0d_lat: got cycle %0d (seen %b) want %0d", t, c, got, exp_cyc); else passes++;
      checks++; if (is_f ? ({f_err, 32'h0, f_rdata} !== {err, exp_rd}) : ({d_err, d_rdata} !== {err, exp_rd}))
        $display("[TB] FAIL rnd%0d_resp: got err %b data %h want err %b data %h", t,
                 is_f ? f_err : d_err, is_f ? {32'h0, f_rdata} : d_rdata, err, exp_rd); else passes++;
      m_ready = 1'b1;
      tick();
    end
  endtask

  // Random contention: a losing request stays pending; the model tracks the data-grant streak
  task automatic test_contention;
    bit pend_f = 1'b0;
    bit pend_d = 1'b0;
    bit exp_f, got;
    int streak = 0;
    int c;
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
    m_ready = 1'b1;
    for (int r = 0; r < 30; r++) begin
      if (!pend_f && $urandom_range(0, 1) == 1) begin
        pend_f = 1'b1; f_addr = 32'($urandom_range(0, 4095)) << 2;
      end
      if (!pend_d && ($urandom_range(0, 3) != 0 || !pend_f)) begin
        pend_d = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 4095)) << 3; d_wdata = {$urandom, $urandom};
      end
      f_req = pend_f; d_req = pend_d;
      m_rdata = {$urandom, $urandom};
      exp_f = pend_f && (!pend_d || streak == MAX_RUN);
      if (exp_f || !pend_f) streak = 0;
      else if (streak < MAX_RUN) streak++;
      tick();
      checks++; if ({f_gnt, d_gnt} !== {exp_f, !exp_f})
        $display("[TB] FAIL cont%0d_winner: got f/d %b want %b", r, {f_gnt, d_gnt}, {exp_f, !exp_f}); else passes++;
      if (exp_f) begin pend_f = 1'b0; f_req = 1'b0; end
      else       begin pend_d = 1'b0; d_req = 1'b0; end
      got = 1'b0;
      c = 1;
      while (!got && c < 8) begin
        tick(); c++;
        got = exp_f ? f_rvalid : d_rvalid;
      end
      checks++; if (!got) $display("[TB] FAIL cont%0d_resp: got no rvalid want rvalid", r); else passes++;
    end
    f_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    idle_inputs();
    m_rdata = '0;
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_starvation();
    test_backpressure_store();
    test_out_of_range();
    test_reset_mid();
    test_random_single();
    test_contention();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
